// File: rtl/dcp_tx_unit_pkg.sv
// Shared definitions for the DCP transmit unit: FSM state encoding,
// request type codes, ASCII constants and the nibble-to-hex helper.
// Build option DCP_TX_CRLF_EN appends CR LF to every word transfer.
package dcp_tx_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_NEXT = 3'd3,
    ST_ACK  = 3'd4,
    ST_REL  = 3'd5
  } tx_state_e;

  localparam logic TYPE_BYTE = 1'b0;
  localparam logic TYPE_WORD = 1'b1;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  // Index of the final character of a word transfer
`ifdef DCP_TX_CRLF_EN
  localparam logic [3:0] WORD_LAST_IDX = 4'd9;
`else
  localparam logic [3:0] WORD_LAST_IDX = 4'd7;
`endif

  // Uppercase hex digit for one nibble
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) c = ASCII_0 + {4'h0, nib};
    else             c = ASCII_A + {4'h0, nib - 4'd10};
    return c;
  endfunction

endpackage

// File: rtl/dcp_tx_unit_if.sv
// Request/acknowledge handshake between a DCP command handler (master)
// and the transmit unit (slave).
interface dcp_tx_unit_if;
  logic        req_tx;
  logic        type_tx;
  logic [31:0] din;
  logic        ack_tx;
  logic        busy;

  modport master (output req_tx, output type_tx, output din,
                  input  ack_tx, input  busy);
  modport slave  (input  req_tx, input  type_tx, input  din,
                  output ack_tx, output busy);
endinterface

// File: rtl/dcp_tx_unit_uart_tx_byte.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit, each
// DIV clocks long. done pulses in the last cycle of the stop bit; start
// is ignored while a frame is in flight. txd comes straight from the
// shift register LSB, so reset drives it high asynchronously.
module uart_tx_byte #(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  logic          busy_q,  busy_d;
  logic [CW-1:0] baud_q,  baud_d;
  logic [3:0]    bit_q,   bit_d;
  logic [9:0]    shift_q, shift_d;
  logic          baud_end;
  logic          frame_end;

  // Bit timing, frame loading and shifting
  always_comb begin
    busy_d    = busy_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    baud_end  = busy_q && (baud_q == BAUD_LAST);
    frame_end = baud_end && (bit_q == 4'd9);
    if (!busy_q) begin
      if (start) begin
        busy_d  = 1'b1;
        baud_d  = '0;
        bit_d   = 4'd0;
        shift_d = {1'b1, data, 1'b0};
      end
    end else if (baud_end) begin
      baud_d  = '0;
      // Refill with ones so the line rests high once the stop bit is out
      shift_d = {1'b1, shift_q[9:1]};
      if (frame_end) begin
        busy_d = 1'b0;
        bit_d  = 4'd0;
      end else begin
        bit_d  = bit_q + 4'd1;
      end
    end else begin
      baud_d = baud_q + 1'b1;
    end
  end

  // Serialiser state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= 4'd0;
      shift_q <= '1;
    end else begin
      busy_q  <= busy_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign txd  = shift_q[0];
  assign done = frame_end;

endmodule

// File: rtl/dcp_tx_unit.sv
// DCP transmit responder: captures one request, formats it as a raw byte
// or as 8 uppercase hex characters (MSB nibble first), serialises the
// characters over UART 8N1 and pulses ack_tx after the final stop bit.
// Build option DCP_TX_CRLF_EN: word transfers are followed by CR LF.
module dcp_tx_unit
  import dcp_tx_unit_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic          clk,
  input  logic          rstn,
  dcp_tx_unit_if.slave  tx,
  output logic          txd
);

  localparam int DIV = CLK_FREQ / BAUD;

  tx_state_e   state_q, state_d;
  logic        type_q,  type_d;
  logic [31:0] din_q,   din_d;
  logic [3:0]  idx_q,   idx_d;

  logic [3:0]  last_idx;
  logic [2:0]  nib_sel;
  logic [3:0]  nib;
  logic [7:0]  char_sel;
  logic        ser_start;
  logic        ser_done;

  // Character selection for the current index
  always_comb begin
    nib_sel  = 3'd7 - idx_q[2:0];
    nib      = din_q[{nib_sel, 2'b00} +: 4];
    last_idx = (type_q == TYPE_WORD) ? WORD_LAST_IDX : 4'd0;
    char_sel = din_q[7:0];
    if (type_q == TYPE_WORD) begin
`ifdef DCP_TX_CRLF_EN
      if (idx_q == 4'd8)      char_sel = ASCII_CR;
      else if (idx_q == 4'd9) char_sel = ASCII_LF;
      else                    char_sel = hex_ascii(nib);
`else
      char_sel = hex_ascii(nib);
`endif
    end
  end

  // Request FSM: next state, capture and character index
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    din_d   = din_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (tx.req_tx) begin
          type_d  = tx.type_tx;
          din_d   = tx.din;
          idx_d   = 4'd0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: begin
        if (ser_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_q == last_idx) begin
          state_d = ST_ACK;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_LOAD;
        end
      end
      ST_ACK: state_d = ST_REL;
      // Hold here until the handler drops its level request
      ST_REL: begin
        if (!tx.req_tx) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request FSM registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      type_q  <= TYPE_BYTE;
      din_q   <= '0;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      din_q   <= din_d;
      idx_q   <= idx_d;
    end
  end

  assign ser_start = (state_q == ST_LOAD);
  assign tx.ack_tx = (state_q == ST_ACK);
  assign tx.busy   = (state_q != ST_IDLE);

  uart_tx_byte #(
    .DIV (DIV)
  ) u_ser (
    .clk   (clk),
    .rstn  (rstn),
    .start (ser_start),
    .data  (char_sel),
    .txd   (txd),
    .done  (ser_done)
  );

endmodule

// File: tb/tb_dcp_tx_unit.sv
// Bench for dcp_tx_unit at CLK_FREQ=16, BAUD=1 (16 clocks per bit).
// Honours DCP_TX_CRLF_EN for the expected word length.
module tb_dcp_tx_unit;

  localparam int DIV = 16;
`ifdef DCP_TX_CRLF_EN
  localparam int         WORD_CHARS = 10;
  localparam logic [7:0] WORD_TAIL  = 8'h0A;
`else
  localparam int         WORD_CHARS = 8;
  localparam logic [7:0] WORD_TAIL  = 8'h00;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic txd;

  dcp_tx_unit_if bus ();

  dcp_tx_unit #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .tx   (bus),
    .txd  (txd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  byte unsigned m_chars[$];
  byte unsigned rx_chars[$];
  int           exp_s[$];
  int           obs[$];
  int           obs_busy[$];
  int           obs_ack[$];

  typedef struct {
    logic        ty;
    logic [31:0] din;
    int          nch;
    logic [7:0]  first;
    logic [7:0]  last;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: characters from the formatting rules, then the ideal
  // per-cycle line level (10 bits of DIV cycles, 2 idle cycles between).
  task automatic model(input logic ty, input logic [31:0] d);
    int nib;
    int v;
    m_chars.delete();
    exp_s.delete();
    if (ty == 1'b0) begin
      m_chars.push_back(d[7:0]);
    end else begin
      for (int k = 0; k < 8; k++) begin
        nib = int'((d >> (28 - 4 * k)) & 32'hF);
        m_chars.push_back((nib < 10) ? 8'(48 + nib) : 8'(55 + nib));
      end
`ifdef DCP_TX_CRLF_EN
      m_chars.push_back(8'h0D);
      m_chars.push_back(8'h0A);
`endif
    end
    for (int c = 0; c < m_chars.size(); c++) begin
      for (int b = 0; b < 10; b++) begin
        if (b == 0)      v = 0;
        else if (b == 9) v = 1;
        else             v = int'((m_chars[c] >> (b - 1)) & 8'h01);
        repeat (DIV) exp_s.push_back(v);
      end
      if (c != m_chars.size() - 1) begin
        exp_s.push_back(1);
        exp_s.push_back(1);
      end
    end
  endtask

  // Independent UART receiver over the captured samples
  task automatic decode();
    int i;
    i = 0;
    rx_chars.delete();
    while (i < obs.size()) begin
      if (obs[i] == 0 && (i + 9 * DIV + DIV / 2) < obs.size()) begin
        byte unsigned c;
        c = 8'h00;
        for (int k = 0; k < 8; k++)
          if (obs[i + DIV / 2 + DIV * (k + 1)] != 0) c = c | 8'(1 << k);
        rx_chars.push_back(c);
        i = i + 9 * DIV + DIV / 2;
      end else begin
        i++;
      end
    end
  endtask

  // One full transfer; hold = extra negedges req stays high after the ack
  // cycle; chg = corrupt din/type right after capture.
  task automatic xfer(input string nm, input logic ty, input logic [31:0] d,
                      input int hold, input bit chg);
    int L, total, drop_at, busy_end, bad, first_bad, n_ack, ack_at, ev;
    model(ty, d);
    L = exp_s.size();
    obs.delete(); obs_busy.delete(); obs_ack.delete();
    @(negedge clk);
    bus.req_tx  = 1'b1;
    bus.type_tx = ty;
    bus.din     = d;
    @(negedge clk);
    check({nm, ".busy_load"}, bus.busy, 1);
    check({nm, ".txd_load"}, txd, 1);
    if (chg) begin
      bus.din     = 32'hFFFF_FFFF;
      bus.type_tx = ~ty;
    end
    drop_at  = L + 1 + hold;
    busy_end = (drop_at > L + 2) ? drop_at : L + 2;
    total    = L + hold + 8;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      obs.push_back(int'(txd));
      obs_busy.push_back(int'(bus.busy));
      obs_ack.push_back(int'(bus.ack_tx));
      if (i == drop_at) bus.req_tx = 1'b0;
    end
    bad = 0; first_bad = -1;
    for (int i = 0; i < total; i++) begin
      ev = (i < L) ? exp_s[i] : 1;
      if (obs[i] != ev) begin bad++; if (first_bad < 0) first_bad = i; end
    end
    check({nm, ".txd_stream_first_bad"}, first_bad, -1);
    bad = 0; first_bad = -1;
    for (int i = 0; i < total; i++) begin
      ev = (i <= busy_end) ? 1 : 0;
      if (obs_busy[i] != ev) begin bad++; if (first_bad < 0) first_bad = i; end
    end
    check({nm, ".busy_trace_first_bad"}, first_bad, -1);
    n_ack = 0; ack_at = -1;
    for (int i = 0; i < total; i++)
      if (obs_ack[i] != 0) begin n_ack++; if (ack_at < 0) ack_at = i; end
    check({nm, ".ack_count"}, n_ack, 1);
    check({nm, ".ack_pos"}, ack_at, L + 1);
    decode();
    check({nm, ".rx_nchars"}, rx_chars.size(), m_chars.size());
    bad = 0;
    for (int c = 0; c < m_chars.size() && c < rx_chars.size(); c++)
      if (rx_chars[c] != m_chars[c]) bad++;
    check({nm, ".rx_chars_bad"}, bad, 0);
  endtask

  vec_t tbl[5];

  initial begin
    logic [31:0] rd;
    int          n_ack, n_low, n_busy;

    tbl[0] = '{1'b0, 32'h0000_0052, 1,          8'h52, 8'h52};
    tbl[1] = '{1'b1, 32'h1357_9BDF, WORD_CHARS, 8'h31, (WORD_CHARS == 10) ? WORD_TAIL : 8'h46};
    tbl[2] = '{1'b0, 32'hABCD_EFFF, 1,          8'hFF, 8'hFF};
    tbl[3] = '{1'b1, 32'hA000_0000, WORD_CHARS, 8'h41, (WORD_CHARS == 10) ? WORD_TAIL : 8'h30};
    tbl[4] = '{1'b1, 32'h0000_0000, WORD_CHARS, 8'h30, (WORD_CHARS == 10) ? WORD_TAIL : 8'h30};

    rstn        = 1'b0;
    bus.req_tx  = 1'b0;
    bus.type_tx = 1'b0;
    bus.din     = '0;
    repeat (3) @(negedge clk);
    check("reset.txd", txd, 1);
    check("reset.busy", bus.busy, 0);
    check("reset.ack", bus.ack_tx, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven transfers
    for (int k = 0; k < 5; k++) begin
      xfer($sformatf("vec%0d", k), tbl[k].ty, tbl[k].din, 0, 1'b0);
      check($sformatf("vec%0d.nchars", k), rx_chars.size(), tbl[k].nch);
      check($sformatf("vec%0d.first", k),
            (rx_chars.size() > 0) ? {1'b0, rx_chars[0]} : 9'h100, {1'b0, tbl[k].first});
      check($sformatf("vec%0d.last", k),
            (rx_chars.size() > 0) ? {1'b0, rx_chars[rx_chars.size() - 1]} : 9'h100,
            {1'b0, tbl[k].last});
      repeat (3) @(negedge clk);
    end

    // req held past the ack must not start a second transfer
    xfer("hold_req", 1'b0, 32'h0000_00A5, 2, 1'b0);
    xfer("rereq", 1'b0, 32'h0000_005A, 0, 1'b0);

    // payload changes after capture are ignored
    xfer("din_change", 1'b1, 32'h2468_ACE0, 0, 1'b1);

    // Reset in the middle of bit 4 of character 3
    rd = 32'hC0FF_EE42;
    model(1'b1, rd);
    @(negedge clk);
    bus.req_tx  = 1'b1;
    bus.type_tx = 1'b1;
    bus.din     = rd;
    @(negedge clk);
    repeat (3 * (10 * DIV + 2) + 4 * DIV + DIV / 2 + 1) @(negedge clk);
    check("rst_mid.txd_before", txd, exp_s[3 * (10 * DIV + 2) + 4 * DIV + DIV / 2]);
    #1;
    rstn       = 1'b0;
    bus.req_tx = 1'b0;
    #1;
    check("rst_mid.txd_async", txd, 1);
    check("rst_mid.busy", bus.busy, 0);
    check("rst_mid.ack", bus.ack_tx, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    n_ack = 0; n_low = 0; n_busy = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.ack_tx) n_ack++;
      if (!txd)       n_low++;
      if (bus.busy)   n_busy++;
    end
    check("rst_mid.no_ack", n_ack, 0);
    check("rst_mid.line_idle", n_low, 0);
    check("rst_mid.stay_idle", n_busy, 0);
    xfer("after_rst", 1'b1, rd, 0, 1'b0);

    // Randomised transfers against the reference model
    for (int r = 0; r < 6; r++) begin
      logic ty;
      ty = 1'($urandom_range(0, 1));
      xfer($sformatf("rand%0d", r), ty, $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
